// File: rtl/pipe_wb_reg_pkg.sv
// Shared defines and package for the writeback pipeline register.
//
// The shared defines (`StallBus, `Pass, `Hold, `Bubb, `RegAddrBus, `RegBus)
// are declared here once, under an include guard. This file must be
// compiled before every other file that uses them.
//
// Package pipe_wb_reg_pkg:
//   stall_t      - type of the stage control bus
//   DEF_AW       - default register address width, taken from `RegAddrBus
//   DEF_DW       - default register data width, taken from `RegBus
//   CNT_W        - width of the retired-write counter
//   stage_adv()  - true when the stall code moves the stage forward
//                  (`Pass or `Bubb)
//
// The optional forwarding feature is selected by the macro PIPE_WB_FWD_EN.
`ifndef PIPE_WB_SHARED_DEFINES
`define PIPE_WB_SHARED_DEFINES
`define StallBus   1:0
`define Pass       2'b00
`define Hold       2'b01
`define Bubb       2'b10
`define RegAddrBus 4:0
`define RegBus     31:0
`endif

package pipe_wb_reg_pkg;

  typedef logic [`StallBus] stall_t;

  localparam int DEF_AW = $bits(logic [`RegAddrBus]);
  localparam int DEF_DW = $bits(logic [`RegBus]);
  localparam int CNT_W  = 32;

  // `Hold and the unused code 2'b11 both freeze the stage.
  function automatic logic stage_adv(input stall_t s);
    return (s == `Pass) || (s == `Bubb);
  endfunction

endpackage

// File: rtl/pipe_wb_reg_fwd_match.sv
// wb_fwd_match: priority matcher for one forwarding query.
//
// Parameters:
//   NLVL - number of priority levels (level 0 is the newest)
//   NCH  - entries per level
//   AW   - address width
//   DW   - data width
// Ports:
//   ent_addr_i  [NLVL*NCH*AW] - entry addresses; entry (lvl, ch) sits at
//                               index lvl*NCH+ch, with index 0 in the LSBs
//   ent_write_i [NLVL*NCH]    - entry write-valid flags
//   ent_data_i  [NLVL*NCH*DW] - entry data
//   q_addr_i    [AW]          - query address; address 0 never hits
//   hit_o                     - a matching entry exists
//   data_o      [DW]          - data of the winning entry, 0 on a miss
module wb_fwd_match #(
  parameter int NLVL = 3,
  parameter int NCH  = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic [NLVL*NCH*AW-1:0] ent_addr_i,
  input  logic [NLVL*NCH-1:0]    ent_write_i,
  input  logic [NLVL*NCH*DW-1:0] ent_data_i,
  input  logic [AW-1:0]          q_addr_i,
  output logic                   hit_o,
  output logic [DW-1:0]          data_o
);

  // Walk the entries from lowest to highest priority so that the last match
  // wins: older levels first, and lower channels before higher ones inside
  // each level.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int lvl = NLVL - 1; lvl >= 0; lvl--) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (ent_write_i[lvl*NCH + ch] &&
            (ent_addr_i[(lvl*NCH + ch)*AW +: AW] == q_addr_i) &&
            (q_addr_i != '0)) begin
          hit_o  = 1'b1;
          data_o = ent_data_i[(lvl*NCH + ch)*DW +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/pipe_wb_reg.sv
// pipe_wb_reg: MEM->WB pipeline register with a writeback counter and,
// optionally, a retired-write history used for operand forwarding.
//
// Configuration macro: PIPE_WB_FWD_EN
//   defined   - history shift register and NQ query matchers are built
//   undefined - no history storage; q_hit_o and q_data_o are tied to 0
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   stall               - `Pass loads, `Bubb clears, anything else holds
//   rd_addr_i/_write_i/_data_i - per-channel write requests from MEM
//                         (channel 0 in the LSBs)
//   rd_addr_o/_write_o/_data_o - registered requests to WB / register file
//   q_addr_i            - forwarding query addresses (NQ ports)
//   q_hit_o, q_data_o   - per-query hit flag and data
//   wb_count_o          - running count of retired valid writes (wraps)
module pipe_wb_reg
  import pipe_wb_reg_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int HDEPTH = 2,
  parameter int NQ     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [`StallBus]    stall,
  input  logic [NCH*AW-1:0]   rd_addr_i,
  input  logic [NCH-1:0]      rd_write_i,
  input  logic [NCH*DW-1:0]   rd_data_i,
  output logic [NCH*AW-1:0]   rd_addr_o,
  output logic [NCH-1:0]      rd_write_o,
  output logic [NCH*DW-1:0]   rd_data_o,
  input  logic [NQ*AW-1:0]    q_addr_i,
  output logic [NQ-1:0]       q_hit_o,
  output logic [NQ*DW-1:0]    q_data_o,
  output logic [CNT_W-1:0]    wb_count_o
);

  logic [NCH*AW-1:0] addr_q, addr_d;
  logic [NCH-1:0]    write_q, write_d;
  logic [NCH*DW-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NCH-1:0]    wr_mask;
  logic [CNT_W-1:0]  wr_inc;

  // A write to x0 is captured but never marked valid.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_mask
    assign wr_mask[gi] = rd_write_i[gi] && (rd_addr_i[gi*AW +: AW] != '0);
  end

  always_comb begin
    wr_inc = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      wr_inc = wr_inc + CNT_W'(wr_mask[ch]);
    end
  end

  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    data_d  = data_q;
    count_d = count_q;
    case (stall)
      `Pass: begin
        addr_d  = rd_addr_i;
        write_d = wr_mask;
        data_d  = rd_data_i;
        count_d = count_q + wr_inc;
      end
      `Bubb: begin
        addr_d  = '0;
        write_d = '0;
        data_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      write_q <= write_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign rd_addr_o  = addr_q;
  assign rd_write_o = write_q;
  assign rd_data_o  = data_q;
  assign wb_count_o = count_q;

`ifdef PIPE_WB_FWD_EN
  localparam int NLVL = HDEPTH + 1;

  logic [NCH*AW-1:0] hist_addr_q  [HDEPTH];
  logic [NCH*AW-1:0] hist_addr_d  [HDEPTH];
  logic [NCH-1:0]    hist_write_q [HDEPTH];
  logic [NCH-1:0]    hist_write_d [HDEPTH];
  logic [NCH*DW-1:0] hist_data_q  [HDEPTH];
  logic [NCH*DW-1:0] hist_data_d  [HDEPTH];
  logic              adv;

  logic [NLVL*NCH*AW-1:0] ent_addr;
  logic [NLVL*NCH-1:0]    ent_write;
  logic [NLVL*NCH*DW-1:0] ent_data;

  // The history moves whenever the stage moves, so a bubble pushes the
  // zeroed stage contents into slot 0 and ages everything else.
  assign adv = stage_adv(stall);

  for (genvar gi = 0; gi < HDEPTH; gi++) begin : g_hist
    if (gi == 0) begin : g_head
      assign hist_addr_d[gi]  = adv ? addr_q  : hist_addr_q[gi];
      assign hist_write_d[gi] = adv ? write_q : hist_write_q[gi];
      assign hist_data_d[gi]  = adv ? data_q  : hist_data_q[gi];
    end else begin : g_tail
      assign hist_addr_d[gi]  = adv ? hist_addr_q[gi-1]  : hist_addr_q[gi];
      assign hist_write_d[gi] = adv ? hist_write_q[gi-1] : hist_write_q[gi];
      assign hist_data_d[gi]  = adv ? hist_data_q[gi-1]  : hist_data_q[gi];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        hist_addr_q[gi]  <= '0;
        hist_write_q[gi] <= '0;
        hist_data_q[gi]  <= '0;
      end else begin
        hist_addr_q[gi]  <= hist_addr_d[gi];
        hist_write_q[gi] <= hist_write_d[gi];
        hist_data_q[gi]  <= hist_data_d[gi];
      end
    end

    // Level 0 is the live stage; history slot k is level k+1.
    assign ent_addr [(gi+1)*NCH*AW +: NCH*AW] = hist_addr_q[gi];
    assign ent_write[(gi+1)*NCH    +: NCH]    = hist_write_q[gi];
    assign ent_data [(gi+1)*NCH*DW +: NCH*DW] = hist_data_q[gi];
  end

  assign ent_addr [0 +: NCH*AW] = addr_q;
  assign ent_write[0 +: NCH]    = write_q;
  assign ent_data [0 +: NCH*DW] = data_q;

  for (genvar gi = 0; gi < NQ; gi++) begin : g_query
    wb_fwd_match #(
      .NLVL (NLVL),
      .NCH  (NCH),
      .AW   (AW),
      .DW   (DW)
    ) u_match (
      .ent_addr_i  (ent_addr),
      .ent_write_i (ent_write),
      .ent_data_i  (ent_data),
      .q_addr_i    (q_addr_i[gi*AW +: AW]),
      .hit_o       (q_hit_o[gi]),
      .data_o      (q_data_o[gi*DW +: DW])
    );
  end
`else
  logic unused_q_addr;

  assign unused_q_addr = ^q_addr_i;
  assign q_hit_o       = '0;
  assign q_data_o      = '0;
`endif

endmodule

// File: tb/tb_pipe_wb_reg.sv
// Directed testbench for pipe_wb_reg (default parameters). Expected
// forwarding results depend on whether PIPE_WB_FWD_EN is defined.
module tb_pipe_wb_reg;

  localparam int NCH = 2;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int HDEPTH = 2;
  localparam int NQ = 2;
`ifdef PIPE_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [`StallBus]  stall;
  logic [NCH*AW-1:0] rd_addr_i;
  logic [NCH-1:0]    rd_write_i;
  logic [NCH*DW-1:0] rd_data_i;
  logic [NCH*AW-1:0] rd_addr_o;
  logic [NCH-1:0]    rd_write_o;
  logic [NCH*DW-1:0] rd_data_o;
  logic [NQ*AW-1:0]  q_addr_i;
  logic [NQ-1:0]     q_hit_o;
  logic [NQ*DW-1:0]  q_data_o;
  logic [31:0]       wb_count_o;

  int n_chk;
  int n_fail;
  int step;

  pipe_wb_reg #(
    .NCH(NCH), .DW(DW), .AW(AW), .HDEPTH(HDEPTH), .NQ(NQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .rd_addr_i  (rd_addr_i),
    .rd_write_i (rd_write_i),
    .rd_data_i  (rd_data_i),
    .rd_addr_o  (rd_addr_o),
    .rd_write_o (rd_write_o),
    .rd_data_o  (rd_data_o),
    .q_addr_i   (q_addr_i),
    .q_hit_o    (q_hit_o),
    .q_data_o   (q_data_o),
    .wb_count_o (wb_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic w,
                        input logic [DW-1:0] d);
    rd_addr_i[ch*AW +: AW] = a;
    rd_write_i[ch]         = w;
    rd_data_i[ch*DW +: DW] = d;
  endtask

  task automatic set_q(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    q_addr_i[0 +: AW]  = a0;
    q_addr_i[AW +: AW] = a1;
  endtask

  // One clock, then settle past the edge before sampling.
  task automatic tick(input string what);
    @(posedge clk);
    #1;
    step++;
    $display("step %0d: %s stall=%0d cnt=%0d wr=%b", step, what, stall, wb_count_o, rd_write_o);
  endtask

  function automatic logic fhit(input logic h);
    return FWD ? h : 1'b0;
  endfunction

  function automatic logic [DW-1:0] fdat(input logic [DW-1:0] d);
    return FWD ? d : '0;
  endfunction

  initial begin
    n_chk = 0; n_fail = 0; step = 0;
    rst = 1'b1; stall = `Hold;
    rd_addr_i = '0; rd_write_i = '0; rd_data_i = '0; q_addr_i = '0;
    set_ch(0, 5'd3, 1'b1, 32'hFFFF_0000);
    set_ch(1, 5'd9, 1'b1, 32'h1234_5678);
    set_q(5'd3, 5'd9);
    tick("reset");
    chk("rst_addr", 64'(rd_addr_o), 64'h0);
    chk("rst_write", 64'(rd_write_o), 64'h0);
    chk("rst_data", 64'(rd_data_o), 64'h0);
    chk("rst_count", 64'(wb_count_o), 64'h0);
    chk("rst_qhit", 64'(q_hit_o), 64'h0);

    // Basic capture.
    rst = 1'b0; stall = `Pass;
    set_ch(0, 5'd3, 1'b1, 32'hA5);
    set_ch(1, 5'd0, 1'b0, 32'h0);
    tick("pass a3");
    chk("p1_write0", 64'(rd_write_o[0]), 64'h1);
    chk("p1_data0", 64'(rd_data_o[0 +: DW]), 64'hA5);
    chk("p1_addr0", 64'(rd_addr_o[0 +: AW]), 64'h3);
    chk("p1_count", 64'(wb_count_o), 64'h1);
    chk("p1_qhit0", 64'(q_hit_o[0]), 64'(fhit(1'b1)));
    chk("p1_qdat0", 64'(q_data_o[0 +: DW]), 64'(fdat(32'hA5)));

    // x0 write suppressed but its data still captured.
    set_ch(0, 5'd6, 1'b0, 32'h12);
    set_ch(1, 5'd0, 1'b1, 32'hDEAD);
    set_q(5'd0, 5'd3);
    tick("pass x0");
    chk("x0_write1", 64'(rd_write_o[1]), 64'h0);
    chk("x0_data1", 64'(rd_data_o[DW +: DW]), 64'hDEAD);
    chk("x0_count", 64'(wb_count_o), 64'h1);
    chk("x0_qhit0", 64'(q_hit_o[0]), 64'h0);
    chk("x0_qdat0", 64'(q_data_o[0 +: DW]), 64'h0);
    chk("x0_qhit1", 64'(q_hit_o[1]), 64'(fhit(1'b1)));
    chk("x0_qdat1", 64'(q_data_o[DW +: DW]), 64'(fdat(32'hA5)));

    // Capture then hold (last hold cycle uses the undefined code).
    set_ch(0, 5'd5, 1'b1, 32'h11);
    set_ch(1, 5'd0, 1'b0, 32'h0);
    tick("pass a5");
    chk("a5_data0", 64'(rd_data_o[0 +: DW]), 64'h11);
    chk("a5_count", 64'(wb_count_o), 64'h2);
    set_ch(0, 5'd8, 1'b1, 32'h99);
    set_ch(1, 5'd2, 1'b1, 32'h77);
    for (int i = 0; i < 3; i++) begin
      stall = (i == 2) ? 2'b11 : `Hold;
      tick("hold");
      chk("hold_data0", 64'(rd_data_o[0 +: DW]), 64'h11);
      chk("hold_addr0", 64'(rd_addr_o[0 +: AW]), 64'h5);
      chk("hold_write", 64'(rd_write_o), 64'h1);
      chk("hold_count", 64'(wb_count_o), 64'h2);
    end

    // Three writes to addr 7, then a same-cycle double write to addr 9.
    stall = `Pass;
    set_ch(1, 5'd0, 1'b0, 32'h0);
    set_q(5'd7, 5'd9);
    for (int i = 1; i <= 3; i++) begin
      set_ch(0, 5'd7, 1'b1, DW'(i));
      tick("pass a7");
    end
    chk("a7_count", 64'(wb_count_o), 64'h5);
    chk("a7_qhit", 64'(q_hit_o[0]), 64'(fhit(1'b1)));
    chk("a7_qdat", 64'(q_data_o[0 +: DW]), 64'(fdat(32'h3)));
    set_ch(0, 5'd9, 1'b1, 32'hB0);
    set_ch(1, 5'd9, 1'b1, 32'hB1);
    tick("pass a9x2");
    chk("a9_count", 64'(wb_count_o), 64'h7);
    chk("a9_qhit", 64'(q_hit_o[1]), 64'(fhit(1'b1)));
    chk("a9_qdat", 64'(q_data_o[DW +: DW]), 64'(fdat(32'hB1)));
    chk("a7_slot0", 64'(q_data_o[0 +: DW]), 64'(fdat(32'h3)));

    // Bubble ages addr 4 through the history and out.
    set_ch(0, 5'd4, 1'b1, 32'h44);
    set_ch(1, 5'd0, 1'b0, 32'h0);
    set_q(5'd4, 5'd9);
    tick("pass a4");
    chk("a4_count", 64'(wb_count_o), 64'h8);
    stall = `Bubb;
    tick("bubble");
    chk("bub_data", 64'(rd_data_o), 64'h0);
    chk("bub_addr", 64'(rd_addr_o), 64'h0);
    chk("bub_write", 64'(rd_write_o), 64'h0);
    chk("bub_count", 64'(wb_count_o), 64'h8);
    chk("bub_qhit", 64'(q_hit_o[0]), 64'(fhit(1'b1)));
    chk("bub_qdat", 64'(q_data_o[0 +: DW]), 64'(fdat(32'h44)));
    tick("bubble");
    chk("bub2_qhit", 64'(q_hit_o[0]), 64'(fhit(1'b1)));
    tick("bubble");
    chk("bub3_qhit", 64'(q_hit_o[0]), 64'h0);
    chk("bub3_qdat", 64'(q_data_o[0 +: DW]), 64'h0);
    chk("bub3_count", 64'(wb_count_o), 64'h8);

    // Fill history, then reset during hold.
    stall = `Pass;
    for (int i = 10; i <= 12; i++) begin
      set_ch(0, AW'(i), 1'b1, DW'(i));
      tick("pass fill");
    end
    set_q(5'd11, 5'd12);
    #1;
    chk("fill_count", 64'(wb_count_o), 64'd11);
    chk("fill_qhit", 64'(q_hit_o), 64'(FWD ? 2'b11 : 2'b00));
    chk("fill_qdat0", 64'(q_data_o[0 +: DW]), 64'(fdat(32'd11)));
    stall = `Hold; rst = 1'b1;
    tick("reset in hold");
    chk("rh_data", 64'(rd_data_o), 64'h0);
    chk("rh_write", 64'(rd_write_o), 64'h0);
    chk("rh_count", 64'(wb_count_o), 64'h0);
    chk("rh_qhit", 64'(q_hit_o), 64'h0);
    rst = 1'b0; stall = `Pass;
    set_ch(0, 5'd13, 1'b1, 32'hD);
    set_q(5'd13, 5'd12);
    tick("pass after reset");
    chk("ar_data0", 64'(rd_data_o[0 +: DW]), 64'hD);
    chk("ar_count", 64'(wb_count_o), 64'h1);
    chk("ar_qhit", 64'(q_hit_o), 64'(FWD ? 2'b01 : 2'b00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
